// File: rtl/d_grf_mp_pkg.sv
// d_grf_mp_pkg: shared defaults and the hard-wired zero register address for the register file.
package d_grf_mp_pkg;
    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NR   = 2;
    localparam int DEF_NW   = 2;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register pending-producer bits plus a registered pending count.
//   clk, reset      : clock, synchronous active-high reset
//   wr_en/wr_addr   : write-back ports, each enabled write clears its register's bit
//   iss_en/iss_addr : issue marks the destination pending
//   flush           : clears every bit, dropping a same-cycle issue
//   busy            : current busy bits (bit REG_ZERO always 0)
//   pend_cnt        : population count of busy, updated on the same edge
module grf_scoreboard
    import d_grf_mp_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int NW = DEF_NW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NW-1:0]     wr_en,
    input  logic [NW*AW-1:0]  wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       pend_cnt
);
    localparam int DEPTH = 2**AW;
    logic [DEPTH-1:0] r_busy, w_next, w_clr, w_set;
    logic [AW:0]      r_cnt, w_cnt;
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int j = 0; j < NW; j++)
            if (wr_en[j]) w_clr[wr_addr[j*AW +: AW]] = 1'b1;
        if (iss_en) w_set[iss_addr] = 1'b1;
        // issue is applied after the clear so a same-cycle issue and write leave the bit set
        w_next = flush ? '0 : (w_set | (r_busy & ~w_clr));
        w_next[REG_ZERO] = 1'b0;
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) w_cnt = w_cnt + (AW+1)'(w_next[i]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next;
            r_cnt  <= w_cnt;
        end
    end
    assign busy     = r_busy;
    assign pend_cnt = r_cnt;
endmodule

// File: rtl/d_grf_mp.sv
// d_grf_mp: multi-ported general register file with write-through bypass and pending-producer scoreboard.
//   clk, reset        : clock, synchronous active-high reset (clears data, busy bits, count)
//   rd_addr/rd_data   : NR packed combinational read ports, bypassed from same-cycle writes
//   rd_busy           : addressed register has a pending producer not being written this cycle
//   wr_en/wr_addr/... : NW packed write ports, higher port wins on address collision
//   iss_en/iss_addr   : mark a destination register pending
//   flush             : clear all pending marks
//   pend_cnt          : number of pending registers
module d_grf_mp
    import d_grf_mp_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int NR = DEF_NR,
    parameter int NW = DEF_NW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NR*AW-1:0]  rd_addr,
    output logic [NR*DW-1:0]  rd_data,
    output logic [NR-1:0]     rd_busy,
    input  logic [NW-1:0]     wr_en,
    input  logic [NW*AW-1:0]  wr_addr,
    input  logic [NW*DW-1:0]  wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [AW:0]       pend_cnt
);
    localparam int DEPTH = 2**AW;
    if (NR < 1 || NR > 4 || NW < 1 || NW > 2 || DW < 1 || AW < 1) begin : g_bad_param
        $error("d_grf_mp: parameter out of legal range");
    end
    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] w_busy;
    // later ports are written last, so port 1 wins on a shared address
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int j = 0; j < NW; j++)
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) != REG_ZERO)
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
    end
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_rd;
        logic          w_hit;
        assign w_ra = rd_addr[k*AW +: AW];
        always_comb begin
            w_rd  = r_mem[w_ra];
            w_hit = 1'b0;
            for (int j = 0; j < NW; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == w_ra) begin
                    w_hit = 1'b1;
                    w_rd  = wr_data[j*DW +: DW];
                end
            if (int'(w_ra) == REG_ZERO) begin
                w_rd  = '0;
                w_hit = 1'b0;
            end
        end
        assign rd_data[k*DW +: DW] = w_rd;
        assign rd_busy[k]          = w_busy[w_ra] & ~w_hit;
    end
    grf_scoreboard #(.AW(AW), .NW(NW)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (w_busy),
        .pend_cnt (pend_cnt)
    );
endmodule

// File: tb/tb_d_grf_mp.sv
// tb_d_grf_mp: table-driven check of reads, bypass, write arbitration, scoreboard, flush and reset.
module tb_d_grf_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  pend_cnt;
    int          errors = 0;
    int          checks = 0;

    d_grf_mp dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic [5:0]  ep;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("%s_data_a%0d", name, a), rd_data, 64'h0);
            chk($sformatf("%s_busy_a%0d", name, a), {62'h0, rd_busy}, 64'h0);
        end
        chk({name, "_pend"}, {58'h0, pend_cnt}, 64'h0);
    endtask

    initial begin
        tv[0]  = '{5'd3, 5'd5, 2'b01, 5'd3, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h0, 2'b00, 6'd0};
        tv[1]  = '{5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h0, 2'b00, 6'd0};
        tv[2]  = '{5'd5, 5'd5, 2'b11, 5'd5, 5'd5, 32'hAAAA0000, 32'h0000BBBB, 1'b0, 5'd0, 1'b0, 32'h0000BBBB, 32'h0000BBBB, 2'b00, 6'd0};
        tv[3]  = '{5'd5, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000BBBB, 32'h12345678, 2'b00, 6'd0};
        tv[4]  = '{5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 6'd0};
        tv[5]  = '{5'd0, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0000BBBB, 2'b00, 6'd0};
        tv[6]  = '{5'd7, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0000BBBB, 2'b01, 6'd1};
        tv[7]  = '{5'd7, 5'd7, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 1'b0, 32'h77, 32'h77, 2'b00, 6'd1};
        tv[8]  = '{5'd7, 5'd5, 2'b10, 5'd0, 5'd7, 32'h0, 32'h88, 1'b1, 5'd7, 1'b0, 32'h88, 32'h0000BBBB, 2'b00, 6'd0};
        tv[9]  = '{5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h88, 32'h88, 2'b11, 6'd1};
        tv[10] = '{5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h88, 2'b10, 6'd1};
        tv[11] = '{5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h0, 32'h88, 2'b10, 6'd1};
        tv[12] = '{5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h88, 32'h88, 2'b00, 6'd0};

        idle();
        rd_addr = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_all_zero("rst");

        for (int v = 0; v < 13; v++) begin
            rd_addr = {tv[v].ra1, tv[v].ra0};
            wr_en   = tv[v].we;
            wr_addr = {tv[v].wa1, tv[v].wa0};
            wr_data = {tv[v].wd1, tv[v].wd0};
            iss_en  = tv[v].ie;
            iss_addr = tv[v].ia;
            flush   = tv[v].fl;
            #1;
            chk($sformatf("v%0d_rd0", v), {32'h0, rd_data[31:0]}, {32'h0, tv[v].e0});
            chk($sformatf("v%0d_rd1", v), {32'h0, rd_data[63:32]}, {32'h0, tv[v].e1});
            chk($sformatf("v%0d_busy", v), {62'h0, rd_busy}, {62'h0, tv[v].eb});
            chk($sformatf("v%0d_pend", v), {58'h0, pend_cnt}, {58'h0, tv[v].ep});
            step();
            idle();
        end

        for (int a = 1; a < 32; a++) begin
            iss_en = 1'b1;
            iss_addr = 5'(a);
            step();
        end
        idle();
        rd_addr = {5'd31, 5'd1};
        #1;
        chk("fill_pend", {58'h0, pend_cnt}, 64'd31);
        chk("fill_busy", {62'h0, rd_busy}, 64'h3);
        flush = 1'b1;
        iss_en = 1'b1;
        iss_addr = 5'd9;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'h0, 32'h44};
        step();
        idle();
        rd_addr = {5'd4, 5'd9};
        #1;
        chk("flush_pend", {58'h0, pend_cnt}, 64'd0);
        chk("flush_busy9", {63'h0, rd_busy[0]}, 64'h0);
        chk("flush_wr4", {32'h0, rd_data[63:32]}, 64'h44);

        for (int a = 0; a < 4; a++) begin
            iss_en = 1'b1;
            iss_addr = (a == 3) ? 5'd6 : 5'(a + 2);
            step();
        end
        idle();
        rd_addr = {5'd6, 5'd3};
        #1;
        chk("pre_rst_pend", {58'h0, pend_cnt}, 64'd4);
        chk("pre_rst_busy", {62'h0, rd_busy}, 64'h3);
        chk("pre_rst_data3", {32'h0, rd_data[31:0]}, 64'h12345678);
        reset = 1'b1;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hDEAD};
        iss_en = 1'b1;
        iss_addr = 5'd10;
        step();
        reset = 1'b0;
        idle();
        check_all_zero("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/d_grf_mp.md
D_GRF_MP -- requirements
Module: d_grf_mp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; depth is 2**AW registers.
REQ-003 SHALL have parameter NR, default 2, read-port count, legal range 1..4.
REQ-004 SHALL have parameter NW, default 2, write-port count, legal range 1..2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rd_addr, input, NR*AW bits: packed read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port rd_data, output, NR*DW bits: packed read data.
REQ-009 SHALL have port rd_busy, output, NR bits: the register addressed by each read port has a pending producer.
REQ-010 SHALL have port wr_en, input, NW bits: per-port write enable.
REQ-011 SHALL have port wr_addr, input, NW*AW bits: packed write addresses.
REQ-012 SHALL have port wr_data, input, NW*DW bits: packed write data.
REQ-013 SHALL have port iss_en, input, 1 bit: mark a destination register pending.
REQ-014 SHALL have port iss_addr, input, AW bits: destination register being issued.
REQ-015 SHALL have port flush, input, 1 bit: clear all pending marks.
REQ-016 SHALL have port pend_cnt, output, AW+1 bits: number of registers currently pending.

Function
REQ-017 Register 0 SHALL read as 0 at all times; writes to it and issues to it SHALL be ignored.
REQ-018 On the clk edge, a write with wr_en[j]=1 and wr_addr[j]!=0 SHALL update that register with wr_data[j].
REQ-019 If both write ports target the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 Reads SHALL be combinational, with write-through bypass: when a read address matches an enabled nonzero write address, rd_data SHALL return the winning wr_data in the same cycle.
REQ-021 The scoreboard SHALL hold 2**AW busy bits; bit 0 SHALL be constant 0.
REQ-022 On the clk edge, iss_en=1 with iss_addr!=0 SHALL set busy[iss_addr].
REQ-023 An enabled write to a nonzero address SHALL clear that address's busy bit on the clk edge.
REQ-024 An issue and a write to the same address in the same cycle SHALL leave the bit set, because the issue is the newer producer.
REQ-025 flush=1 SHALL clear all busy bits on the clk edge; a same-cycle issue SHALL be dropped; same-cycle writes SHALL still update data.
REQ-026 rd_busy[k] SHALL equal busy[rd_addr[k]] AND NOT (an enabled write to rd_addr[k] this cycle), so bypassed operands are never reported busy.
REQ-027 pend_cnt SHALL be a registered population count of the busy bits, updated in the same edge as the bits; it SHALL never exceed 2**AW-1.
REQ-028 Parameter values outside their legal range SHALL be rejected at elaboration.

Reset
REQ-029 While reset=1 on a clk edge, all registers SHALL be cleared to 0, all busy bits cleared and pend_cnt set to 0; reset SHALL override writes, issues and flush.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge with no partial updates.
REQ-031 After reset, rd_data SHALL be 0 and rd_busy 0 for every address, unless bypassed.

Structure
REQ-032 A shared package SHALL hold the default DW/AW/NR/NW constants and the register-0 address constant.
REQ-033 The busy-bit table plus pend_cnt SHALL be one sub-module named grf_scoreboard; storage, write arbitration and bypass SHALL stay in d_grf_mp.

Verification
REQ-034 Reset, then read all addresses on every port -> every rd_data=0, rd_busy=0, pend_cnt=0.
REQ-035 Write port0 addr 3 = 0x12345678 and read port0 addr 3 in the same cycle -> rd_data=0x12345678 combinationally; the next cycle reads it back from storage.
REQ-036 Both write ports write addr 5 (port0=0xAAAA0000, port1=0x0000BBBB) -> bypass and stored value both 0x0000BBBB; a write of 0xFFFFFFFF to addr 0 -> addr 0 still reads 0.
REQ-037 Issue addr 7 -> rd_busy=1 for addr 7 and pend_cnt=1; a write to 7 alone in the next cycle -> rd_busy=0 in that cycle, pend_cnt=0 after the edge; issue and write of 7 in the same cycle -> bit remains set.
REQ-038 Issue addrs 1..31 over 31 cycles -> pend_cnt=31; flush together with an issue to addr 9 -> pend_cnt=0 and addr 9 not busy.
REQ-039 With 4 registers pending and data written, assert reset for one cycle -> all data 0, pend_cnt=0; a write in the reset cycle is discarded.
